// File: rtl/sevenseg_pkg.sv
// Shared constants for the common-anode seven-segment capture path.
// Segment patterns are {g,f,e,d,c,b,a}, active-low (0 = LED on).
package sevenseg_pkg;

  localparam int NDIG_MAX = 8;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] digit;
  } dec_t;

endpackage

// File: rtl/sevenseg_ca_decode.sv
// Combinational decode of one active-low segment pattern into BCD,
// flagging all-off as blank and any non-decimal pattern as an error.
module sevenseg_ca_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output dec_t       dec
);

  always_comb begin
    dec.err   = 1'b0;
    dec.blank = 1'b0;
    dec.digit = 4'h0;
    case (seg)
      SEG_0:     dec.digit = 4'd0;
      SEG_1:     dec.digit = 4'd1;
      SEG_2:     dec.digit = 4'd2;
      SEG_3:     dec.digit = 4'd3;
      SEG_4:     dec.digit = 4'd4;
      SEG_5:     dec.digit = 4'd5;
      SEG_6:     dec.digit = 4'd6;
      SEG_7:     dec.digit = 4'd7;
      SEG_8:     dec.digit = 4'd8;
      SEG_9:     dec.digit = 4'd9;
      SEG_BLANK: dec.blank = 1'b1;
      default: begin
        dec.digit = 4'hF;
        dec.err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_capture.sv
// Receive side of a multiplexed common-anode display: qualifies each
// digit dwell for stability, decodes it once and latches per-digit results.
module sevenseg_scan_capture
  import sevenseg_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   an_in,
  output logic [4*NDIG-1:0] digits_out,
  output logic [NDIG-1:0]   blank_out,
  output logic [NDIG-1:0]   err_out,
  output logic              frame_valid,
  output logic              multi_an
);

  localparam int CW = $clog2(STABLE_CYC);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYC - 1);

  logic [6:0]      seg_q;
  logic [NDIG-1:0] an_q;
  logic [6:0]      prev_seg;
  logic [IW-1:0]   prev_idx;
  logic            prev_act;
  logic [CW-1:0]   cnt_r;
  logic            done_r;
  logic [NDIG-1:0] seen;

  logic [IW-1:0]   idx;
  logic [3:0]      nact;
  logic            active;
  logic            multi;
  logic            clear;
  logic [CW-1:0]   cnt;
  logic            capture;
  logic [NDIG-1:0] cap_mask;
  dec_t            dec;

  always_comb begin
    idx  = '0;
    nact = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (!an_q[i]) begin
        nact = nact + 4'd1;
        idx  = IW'(i);
      end
    end
    active = (nact == 4'd1);
    multi  = (nact > 4'd1);
  end

  // cnt is the stability count belonging to the current registered sample;
  // cnt_r carries it forward so a dwell registered at edge E reaches
  // STABLE_CYC-1 in the cycle after edge E+STABLE_CYC-1.
  always_comb begin
    clear    = !active || !prev_act || (idx != prev_idx) || (seg_q != prev_seg);
    cnt      = clear ? '0 : ((cnt_r == CMAX) ? CMAX : cnt_r + CW'(1));
    capture  = active && (cnt == CMAX) && !done_r;
    cap_mask = capture ? (NDIG'(1) << idx) : '0;
  end

  sevenseg_ca_decode u_dec (
    .seg (seg_q),
    .dec (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= '1;
      an_q        <= '1;
      prev_seg    <= '1;
      prev_idx    <= '0;
      prev_act    <= 1'b0;
      cnt_r       <= '0;
      done_r      <= 1'b0;
      seen        <= '0;
      digits_out  <= '0;
      blank_out   <= '1;
      err_out     <= '0;
      frame_valid <= 1'b0;
      multi_an    <= 1'b0;
    end else begin
      seg_q       <= seg_in;
      an_q        <= an_in;
      prev_seg    <= seg_q;
      prev_idx    <= idx;
      prev_act    <= active;
      cnt_r       <= cnt;
      done_r      <= clear ? 1'b0 : (done_r | capture);
      multi_an    <= multi;
      frame_valid <= 1'b0;
      if (capture) begin
        digits_out[4*idx +: 4] <= dec.digit;
        blank_out[idx]         <= dec.blank;
        err_out[idx]           <= dec.err;
        if (&(seen | cap_mask)) begin
          frame_valid <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= seen | cap_mask;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_capture.sv
// Bench for sevenseg_scan_capture: directed and random dwells checked
// against a run-length reference model of the multiplexed display.
module tb_sevenseg_scan_capture;

  localparam int NDIG = 4;
  localparam int SC   = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [6:0]      seg_in = 7'h7F;
  logic [NDIG-1:0] an_in = '1;
  logic [4*NDIG-1:0] digits_out;
  logic [NDIG-1:0] blank_out;
  logic [NDIG-1:0] err_out;
  logic            frame_valid;
  logic            multi_an;

  sevenseg_scan_capture #(.NDIG(NDIG), .STABLE_CYC(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits_out  (digits_out),
    .blank_out   (blank_out),
    .err_out     (err_out),
    .frame_valid (frame_valid),
    .multi_an    (multi_an)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  logic [6:0] pats [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000};

  // Reference model: expected outputs after each edge, plus events that
  // the sample registered at this edge will cause one edge later.
  logic [4*NDIG-1:0] exp_digits;
  logic [NDIG-1:0]   exp_blank, exp_err, seen_m;
  logic              exp_fv, exp_multi;
  logic              pend_cap, pend_multi;
  int                pend_idx;
  logic [6:0]        pend_seg, prev_seg_m;
  logic [NDIG-1:0]   prev_an_m;
  logic              prev_act_m;
  int                run_len;

  function automatic logic [5:0] ref_dec(input logic [6:0] s);
    if (s == 7'h7F) return {1'b0, 1'b1, 4'h0};
    for (int k = 0; k < 10; k++)
      if (pats[k] == s) return {1'b0, 1'b0, 4'(k)};
    return {1'b1, 1'b0, 4'hF};
  endfunction

  task automatic model_edge();
    logic [5:0] d;
    int zeros;
    if (rst) begin
      exp_digits = '0; exp_blank = '1; exp_err = '0;
      exp_fv = 0; exp_multi = 0; pend_cap = 0; pend_multi = 0;
      run_len = 0; prev_act_m = 0; seen_m = '0;
      return;
    end
    exp_fv    = 0;
    exp_multi = pend_multi;
    if (pend_cap) begin
      d = ref_dec(pend_seg);
      exp_digits[4*pend_idx +: 4] = d[3:0];
      exp_blank[pend_idx] = d[4];
      exp_err[pend_idx]   = d[5];
      seen_m[pend_idx]    = 1'b1;
      if (&seen_m) begin
        exp_fv = 1;
        seen_m = '0;
      end
    end
    zeros = $countones(~an_in);
    pend_multi = (zeros >= 2);
    if (zeros == 1) begin
      if (prev_act_m && an_in == prev_an_m && seg_in == prev_seg_m) run_len++;
      else run_len = 1;
    end else begin
      run_len = 0;
    end
    pend_cap = (zeros == 1) && (run_len == SC);
    for (int k = 0; k < NDIG; k++) if (!an_in[k]) pend_idx = k;
    pend_seg   = seg_in;
    prev_act_m = (zeros == 1);
    prev_an_m  = an_in;
    prev_seg_m = seg_in;
  endtask

  task automatic check_all();
    ncmp++;
    assert (digits_out === exp_digits) else begin
      nfail++; $error("FAIL digits_out observed %h expected %h", digits_out, exp_digits);
    end
    ncmp++;
    assert (blank_out === exp_blank) else begin
      nfail++; $error("FAIL blank_out observed %b expected %b", blank_out, exp_blank);
    end
    ncmp++;
    assert (err_out === exp_err) else begin
      nfail++; $error("FAIL err_out observed %b expected %b", err_out, exp_err);
    end
    ncmp++;
    assert (frame_valid === exp_fv) else begin
      nfail++; $error("FAIL frame_valid observed %b expected %b", frame_valid, exp_fv);
    end
    ncmp++;
    assert (multi_an === exp_multi) else begin
      nfail++; $error("FAIL multi_an observed %b expected %b", multi_an, exp_multi);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++; $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic dwell(input logic [NDIG-1:0] a, input logic [6:0] s, input int n);
    an_in = a; seg_in = s;
    repeat (n) tick();
  endtask

  initial begin
    int fv_at, fv_cnt, cap_at, len;
    logic [NDIG-1:0] a;
    logic [6:0] s;

    // reset with arbitrary inputs
    rst = 1; an_in = 4'b1110; seg_in = pats[3];
    repeat (3) tick();
    chk("reset_digits", int'(digits_out), 0);
    chk("reset_blank", int'(blank_out), 4'hF);
    rst = 0; an_in = '1; seg_in = 7'h7F;
    repeat (2) tick();

    // full frame 1,2,3,4
    dwell(4'b1110, pats[1], 12);
    dwell(4'b1101, pats[2], 12);
    dwell(4'b1011, pats[3], 12);
    an_in = 4'b0111; seg_in = pats[4];
    fv_at = 0; fv_cnt = 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (frame_valid) begin fv_cnt++; fv_at = j; end
    end
    chk("frame_digits", int'(digits_out), 16'h4321);
    chk("frame_pulse_count", fv_cnt, 1);
    chk("frame_pulse_edge", fv_at, 9);
    dwell('1, 7'h7F, 3);

    // short dwell then qualifying dwell
    dwell(4'b1110, pats[7], 7);
    dwell('1, 7'h7F, 2);
    chk("short_dwell_digit0", int'(digits_out[3:0]), 1);
    dwell(4'b1110, pats[7], 8);
    dwell('1, 7'h7F, 1);
    chk("exact_dwell_digit0", int'(digits_out[3:0]), 7);

    // glitch inside a SEG_5 dwell, then an invalid dwell
    dwell(4'b1101, pats[5], 5);
    dwell(4'b1101, 7'b0101010, 1);
    dwell(4'b1101, pats[5], 12);
    chk("glitch_digit1", int'(digits_out[7:4]), 5);
    dwell(4'b0111, 7'b0101010, 10);
    chk("invalid_err3", int'(err_out[3]), 1);
    chk("invalid_digit3", int'(digits_out[15:12]), 15);

    // blank on digit 2, then multi-anode
    dwell(4'b1011, 7'h7F, 10);
    chk("blank2", int'(blank_out[2]), 1);
    chk("blank_digit2", int'(digits_out[11:8]), 0);
    dwell(4'b1100, pats[8], 3);
    dwell('1, 7'h7F, 2);

    // reset mid-dwell
    dwell(4'b1101, pats[9], 5);
    rst = 1;
    repeat (2) tick();
    rst = 0;
    cap_at = 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (cap_at == 0 && digits_out[7:4] == 4'd9) cap_at = j;
    end
    chk("reset_mid_dwell_edge", cap_at, 9);

    // random dwells
    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(9))
        0:       a = '1;
        1:       a = 4'($urandom);
        default: a = ~(4'b1 << $urandom_range(NDIG-1));
      endcase
      case ($urandom_range(9))
        0:       s = 7'h7F;
        1, 2:    s = 7'($urandom);
        default: s = pats[$urandom_range(9)];
      endcase
      len = $urandom_range(14, 1);
      dwell(a, s, len);
      if ($urandom_range(5) == 0) dwell(a, 7'($urandom), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_capture.md
# sevenseg_scan_capture

Monitors a multiplexed common-anode seven-segment bus (segment lines plus per-digit anode selects) and reconstructs the displayed BCD digits. It is the receive end of the segment-driver path and is used for self-checking display output and for board-level loopback. Each dwell is qualified by a stability counter before its pattern is decoded. Per-digit results are latched, and a pulse marks each completed frame.

## Interface
- `NDIG`, 4, number of multiplexed digits (2..8)
- `STABLE_CYC`, 8, cycles a dwell must hold unchanged before capture (≥2)
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `seg_in`  in  7  {g,f,e,d,c,b,a}, 0 = LED on
- `an_in`  in  NDIG  anode selects, active-low; bit i = digit i
- `digits_out`  out  4*NDIG  captured digit i at [4i+3:4i]
- `blank_out`  out  NDIG  1 = digit i last captured as all-off (7'h7F)
- `err_out`  out  NDIG  1 = digit i last captured with a non-decimal pattern
- `frame_valid`  out  1  one-cycle pulse: every digit captured since the previous pulse
- `multi_an`  out  1  one-cycle pulse: more than one anode active in a registered sample

## Operation
- `seg_in` and `an_in` are registered once. All logic below uses the registered copies `seg_q` and `an_q`.
- **Dwell qualification**
  - A sample is *active* when exactly one bit of `an_q` is 0. `idx` is that bit's index.
  - Zero active bits: idle. The counter clears to 0 and no capture occurs.
  - Two or more active bits: idle. `multi_an` pulses that cycle.
- **Stability counter `cnt`**, width `$clog2(STABLE_CYC)`
  - Clears to 0 when the sample is idle, or when `{idx, seg_q}` differs from the previous cycle.
  - Otherwise increments, saturating at `STABLE_CYC-1`.
  - Flag `done` prevents re-capture within one dwell. It sets on capture and clears whenever `cnt` clears.
- **Capture** occurs when the sample is active, `cnt == STABLE_CYC-1` and `done == 0`. `seg_q` is decoded as follows:
  - 7'b1000000 → 0, 1111001 → 1, 0100100 → 2, 0110000 → 3, 0011001 → 4, 0010010 → 5, 0000010 → 6, 1111000 → 7, 0000000 → 8, 0010000 → 9. Result: `digit = value`, `blank = 0`, `err = 0`.
  - 7'h7F → `digit = 0`, `blank = 1`, `err = 0`.
  - Any other pattern → `digit = 4'hF`, `blank = 0`, `err = 1`.
  - Only slot `idx` is written. Other slots hold.
- **Frame tracking**
  - `seen[NDIG-1:0]` sets bit `idx` on each capture.
  - When `seen | capture_mask` is all ones, `frame_valid` pulses and `seen` clears in the same edge. The completing capture is not carried into the next frame.
  - Re-capturing an already-seen digit before the frame completes overwrites its slot. `seen` is unchanged.
- **Reset values:** `digits_out` = 0, `blank_out` = all 1, `err_out` = 0, `frame_valid` = 0, `multi_an` = 0. Internally `seen`, `cnt` and `done` are 0.
- Reset asserted mid-dwell discards the partial dwell. Qualification restarts from the first post-reset sample.

## Timing
- **Capture latency:**
  - Inputs settle before edge E, are registered at E, and then stay constant.
  - `cnt` reaches `STABLE_CYC-1` at edge E+`STABLE_CYC`-1.
  - Outputs for that digit update at edge E+`STABLE_CYC`. This is `STABLE_CYC`+1 edges after settling.
- `frame_valid` is high in the same cycle the completing digit's outputs first show the new value.
- `multi_an` goes high one edge after the offending sample is registered.
- A dwell shorter than `STABLE_CYC` registered cycles is never captured.
- A dwell held indefinitely is captured exactly once.
- A segment glitch of one or more cycles within a dwell restarts qualification, and the dwell may be captured again after re-stabilising.
- A change of `idx` with `seg_q` unchanged counts as a new dwell.

## Structure
- Package `sevenseg_pkg` holds:
  - the `SEG_0`..`SEG_9` and `SEG_BLANK` 7-bit constants in {g..a}, active-low form;
  - `NDIG_MAX` = 8.
- Sub-module `sevenseg_ca_decode` is purely combinational: `seg[6:0]` → `{err, blank, digit[3:0]}`. It is instantiated once, on `seg_q`.
- The top module holds the input register, the one-hot/multi check, `cnt`/`done`, the per-digit slots and `seen`.

## Test plan
- **Reset values:** assert `rst` with any inputs → `digits_out` = 0, `blank_out` = 4'hF, `err_out` = 0, no pulses.
- **Full frame:** drive `an_in` = 1110,1101,1011,0111 with patterns for 1,2,3,4, 12 cycles each, `STABLE_CYC` = 8 → `digits_out` = 16'h4321 and `frame_valid` high for exactly one cycle, 9 edges after the start of the fourth dwell.
- **Short dwell:** hold `an_in` = 1110 with `SEG_7` for 7 cycles → no capture. Hold for 8 cycles → digit 0 = 7.
- **Glitch and invalid:** within a `SEG_5` dwell, one cycle of 7'b0101010 → counter restarts and digit = 5 is captured once. A dwell held at 7'b0101010 → `err_out[i]` = 1, digit = F.
- **Blank and multi-anode:** 7'h7F on digit 2 → `blank_out[2]` = 1, `digits_out[11:8]` = 0. `an_in` = 1100 → `multi_an` pulses and no slot changes.
- **Reset mid-dwell:** assert `rst` 5 cycles into a dwell, then release with inputs held → capture occurs 9 edges after release, not earlier.
